// File: rtl/l1d_writeback_buffer.sv
// L1D writeback buffer: address-searchable FIFO of dirty evictions draining to the LC,
// read-miss pass-through with priority, and forwarding of buffered data. Option: WB_COALESCE_EN.
module l1d_writeback_buffer #(
  parameter int PADDR_BITS = 22,
  parameter int DEPTH      = 4,
  parameter int DATA_BITS  = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  l1_valid_in,
  output logic                  l1_ready_out,
  input  logic [PADDR_BITS-1:0] l1_addr_in,
  input  logic [DATA_BITS-1:0]  l1_value_in,
  input  logic                  l1_we_in,
  output logic                  l1_resp_valid_out,
  input  logic                  l1_resp_ready_in,
  output logic [PADDR_BITS-1:0] l1_resp_addr_out,
  output logic [DATA_BITS-1:0]  l1_resp_value_out,
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [PADDR_BITS-1:0] lc_addr_out,
  output logic [DATA_BITS-1:0]  lc_value_out,
  output logic                  lc_we_out,
  output logic                  empty_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_RD, SEND_WB} state_t;
  state_t state_q, state_d;

  logic [PADDR_BITS-1:0] ent_addr [DEPTH];
  logic [DATA_BITS-1:0]  ent_data [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, hit_idx;
  logic [PTR_W:0]        count;
  logic                  rd_pending, resp_pending, out_of_reset;
  logic [PADDR_BITS-1:0] rd_addr_q, resp_addr_q;
  logic [DATA_BITS-1:0]  resp_data_q;
  logic                  accept, wr_acc, rd_hit, rd_miss, alloc, pop, hit;

  assign l1_ready_out = out_of_reset && !rd_pending && !resp_pending && (count != FULL);
  assign accept  = l1_valid_in && l1_ready_out;
  assign wr_acc  = accept && l1_we_in;
  assign rd_hit  = accept && !l1_we_in && hit;
  assign rd_miss = accept && !l1_we_in && !hit;
  assign pop     = (state_q == SEND_WB) && lc_ready_in;

  // Lookup runs on pre-pop state; the last match in age order is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count && ent_addr[rd_ptr + PTR_W'(i)] == l1_addr_in) begin
        hit     = 1'b1;
        hit_idx = rd_ptr + PTR_W'(i);
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic             co_hit, merge;
  logic [PTR_W-1:0] co_idx;

  // The head being presented to the LC must stay stable, so it is excluded.
  always_comb begin
    co_hit = 1'b0;
    co_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count && ent_addr[rd_ptr + PTR_W'(i)] == l1_addr_in &&
          !(i == 0 && state_q == SEND_WB)) begin
        co_hit = 1'b1;
        co_idx = rd_ptr + PTR_W'(i);
      end
    end
  end
  assign alloc = wr_acc && !co_hit;
  assign merge = wr_acc && co_hit;
`else
  assign alloc = wr_acc;
`endif

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q      <= IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rd_pending   <= 1'b0;
      resp_pending <= 1'b0;
      out_of_reset <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_of_reset <= 1'b1;
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (alloc && !pop)      count <= count + 1'b1;
      else if (!alloc && pop) count <= count - 1'b1;
      if (rd_miss)                                 rd_pending <= 1'b1;
      else if (state_q == SEND_RD && lc_ready_in) rd_pending <= 1'b0;
      if (rd_hit)                resp_pending <= 1'b1;
      else if (l1_resp_ready_in) resp_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (alloc) begin
      ent_addr[wr_ptr] <= l1_addr_in;
      ent_data[wr_ptr] <= l1_value_in;
    end
`ifdef WB_COALESCE_EN
    if (merge) ent_data[co_idx] <= l1_value_in;
`endif
    if (rd_miss) rd_addr_q <= l1_addr_in;
    if (rd_hit) begin
      resp_addr_q <= l1_addr_in;
      resp_data_q <= ent_data[hit_idx];
    end
  end

  // A miss accepted while idle goes straight to SEND_RD so it overtakes buffered writebacks.
  always_comb begin
    state_d      = state_q;
    lc_valid_out = 1'b0;
    lc_we_out    = 1'b0;
    lc_addr_out  = '0;
    lc_value_out = '0;
    case (state_q)
      IDLE: begin
        if (rd_pending || rd_miss) state_d = SEND_RD;
        else if (count != '0)      state_d = SEND_WB;
      end
      SEND_RD: begin
        lc_valid_out = 1'b1;
        lc_addr_out  = rd_addr_q;
        if (lc_ready_in) state_d = IDLE;
      end
      SEND_WB: begin
        lc_valid_out = 1'b1;
        lc_we_out    = 1'b1;
        lc_addr_out  = ent_addr[rd_ptr];
        lc_value_out = ent_data[rd_ptr];
        if (lc_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign l1_resp_valid_out = resp_pending;
  assign l1_resp_addr_out  = resp_pending ? resp_addr_q : '0;
  assign l1_resp_value_out = resp_pending ? resp_data_q : '0;
  assign empty_out = (count == '0) && !rd_pending && !resp_pending && (state_q == IDLE);

endmodule

// File: tb/tb_l1d_writeback_buffer.sv
// Scoreboard bench for l1d_writeback_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer contents.
module tb_l1d_writeback_buffer;
  localparam int AW = 22;
  localparam int DW = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk_in = 1'b0;
  logic          rst_N_in = 1'b0;
  logic          l1_valid_in = 1'b0;
  logic          l1_ready_out;
  logic [AW-1:0] l1_addr_in = '0;
  logic [DW-1:0] l1_value_in = '0;
  logic          l1_we_in = 1'b0;
  logic          l1_resp_valid_out;
  logic          l1_resp_ready_in = 1'b0;
  logic [AW-1:0] l1_resp_addr_out;
  logic [DW-1:0] l1_resp_value_out;
  logic          lc_valid_out;
  logic          lc_ready_in = 1'b0;
  logic [AW-1:0] lc_addr_out;
  logic [DW-1:0] lc_value_out;
  logic          lc_we_out;
  logic          empty_out;

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic rand_mode = 1'b0;
  logic lc_force = 1'b0;
  logic resp_force = 1'b1;

  txn_t          mq[$];
  txn_t          exp_resp[$];
  txn_t          lc_log[$];
  logic          exp_rd_pend = 1'b0;
  logic [AW-1:0] exp_rd_addr = '0;
  logic          lc_hold = 1'b0, resp_hold = 1'b0;
  txn_t          lc_prev, resp_prev, t;

  l1d_writeback_buffer #(.PADDR_BITS(AW), .DEPTH(DEPTH), .DATA_BITS(DW)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
    .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
    .l1_resp_valid_out(l1_resp_valid_out), .l1_resp_ready_in(l1_resp_ready_in),
    .l1_resp_addr_out(l1_resp_addr_out), .l1_resp_value_out(l1_resp_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
    .lc_value_out(lc_value_out), .lc_we_out(lc_we_out), .empty_out(empty_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready-signal driver for the LC and response channels.
  initial forever begin
    @(posedge clk_in); #2;
    if (rand_mode) begin
      lc_ready_in      = ($urandom_range(0, 3) != 0);
      l1_resp_ready_in = ($urandom_range(0, 1) == 1);
    end else begin
      lc_ready_in      = lc_force;
      l1_resp_ready_in = resp_force;
    end
  end

  // Monitor: checks presented state, then applies handshakes to the model (lookup before pop).
  initial forever begin
    @(negedge clk_in);
    if (!rst_N_in) begin
      mq.delete();
      exp_resp.delete();
      exp_rd_pend = 1'b0;
      lc_hold = 1'b0;
      resp_hold = 1'b0;
    end else if (mon_en) begin
      chk("ready", 64'(l1_ready_out),
          64'(!exp_rd_pend && exp_resp.size() == 0 && mq.size() < DEPTH));
      chk("empty", 64'(empty_out), 64'(mq.size() == 0 && !exp_rd_pend && exp_resp.size() == 0));
      chk("resp_valid", 64'(l1_resp_valid_out), 64'(exp_resp.size() != 0));
      if (lc_hold) begin
        chk("lc_hold_valid", 64'(lc_valid_out), 64'd1);
        chk("lc_hold_we", 64'(lc_we_out), 64'(lc_prev.we));
        chk("lc_hold_addr", 64'(lc_addr_out), 64'(lc_prev.addr));
        chk("lc_hold_data", lc_value_out, lc_prev.data);
      end
      if (resp_hold) begin
        chk("resp_hold_addr", 64'(l1_resp_addr_out), 64'(resp_prev.addr));
        chk("resp_hold_data", l1_resp_value_out, resp_prev.data);
      end
      lc_hold = lc_valid_out && !lc_ready_in;
      lc_prev = '{lc_we_out, lc_addr_out, lc_value_out};
      resp_hold = l1_resp_valid_out && !l1_resp_ready_in;
      resp_prev = '{1'b0, l1_resp_addr_out, l1_resp_value_out};

      if (l1_resp_valid_out && l1_resp_ready_in) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else begin
          t = exp_resp.pop_front();
          chk("resp_addr", 64'(l1_resp_addr_out), 64'(t.addr));
          chk("resp_data", l1_resp_value_out, t.data);
        end
      end

      if (l1_valid_in && l1_ready_out) begin
        if (l1_we_in) begin
`ifdef WB_COALESCE_EN
          begin
            int ci;
            ci = -1;
            for (int i = mq.size() - 1; i >= 0; i--)
              if (ci < 0 && mq[i].addr == l1_addr_in && !(i == 0 && lc_valid_out && lc_we_out))
                ci = i;
            if (ci >= 0) mq[ci].data = l1_value_in;
            else mq.push_back('{1'b1, l1_addr_in, l1_value_in});
          end
`else
          mq.push_back('{1'b1, l1_addr_in, l1_value_in});
`endif
        end else begin
          int hi;
          hi = -1;
          for (int i = mq.size() - 1; i >= 0; i--)
            if (hi < 0 && mq[i].addr == l1_addr_in) hi = i;
          if (hi >= 0) exp_resp.push_back('{1'b0, l1_addr_in, mq[hi].data});
          else begin
            exp_rd_pend = 1'b1;
            exp_rd_addr = l1_addr_in;
          end
        end
      end

      if (lc_valid_out && lc_ready_in) begin
        lc_log.push_back('{lc_we_out, lc_addr_out, lc_value_out});
        if (lc_we_out) begin
          if (mq.size() == 0) chk("lc_wb_unexpected", 64'd1, 64'd0);
          else begin
            t = mq.pop_front();
            chk("lc_wb_addr", 64'(lc_addr_out), 64'(t.addr));
            chk("lc_wb_data", lc_value_out, t.data);
          end
        end else begin
          chk("lc_rd_expected", 64'(exp_rd_pend), 64'd1);
          chk("lc_rd_addr", 64'(lc_addr_out), 64'(exp_rd_addr));
          exp_rd_pend = 1'b0;
        end
      end
    end
  end

  task automatic l1_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    l1_valid_in = 1'b1;
    l1_we_in    = we;
    l1_addr_in  = a;
    l1_value_in = d;
    do begin @(negedge clk_in); n++; end while (!l1_ready_out && n < 300);
    if (!l1_ready_out) chk("l1_accept_timeout", 64'd0, 64'd1);
    @(posedge clk_in); #1;
    l1_valid_in = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    do begin @(negedge clk_in); n++; end while (!empty_out && n < 500);
    chk(name, 64'(empty_out), 64'd1);
    @(posedge clk_in); #1;
  endtask

  initial begin
    int n0;
    // Reset held with a request offered: nothing may be accepted or presented.
    l1_valid_in = 1'b1;
    l1_we_in    = 1'b1;
    l1_addr_in  = 22'h00040;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", 64'(l1_ready_out), 64'd0);
    chk("rst_lc_valid", 64'(lc_valid_out), 64'd0);
    chk("rst_lc_we", 64'(lc_we_out), 64'd0);
    chk("rst_lc_addr", 64'(lc_addr_out), 64'd0);
    chk("rst_lc_value", lc_value_out, 64'd0);
    chk("rst_resp_valid", 64'(l1_resp_valid_out), 64'd0);
    chk("rst_resp_addr", 64'(l1_resp_addr_out), 64'd0);
    chk("rst_resp_value", l1_resp_value_out, 64'd0);
    chk("rst_empty", 64'(empty_out), 64'd1);
    @(posedge clk_in); #1;
    rst_N_in    = 1'b1;
    l1_valid_in = 1'b0;
    @(posedge clk_in); #1;
    mon_en = 1'b1;
    @(negedge clk_in);
    chk("post_rst_ready", 64'(l1_ready_out), 64'd1);
    @(posedge clk_in); #1;

    // Forwarding from the buffer; the read never reaches the LC.
    n0 = lc_log.size();
    l1_req(1'b1, 22'h00040, 64'hAAAA);
    l1_req(1'b0, 22'h00040, 64'h0);
    @(negedge clk_in);
    chk("t2_resp_valid", 64'(l1_resp_valid_out), 64'd1);
    chk("t2_resp_value", l1_resp_value_out, 64'hAAAA);
    chk("t2_resp_addr", 64'(l1_resp_addr_out), 64'h00040);
    lc_force = 1'b1;
    wait_empty("t2_drain");
    chk("t2_lc_count", 64'(lc_log.size()), 64'(n0 + 1));
    chk("t2_lc_we", 64'(lc_log[n0].we), 64'd1);
    chk("t2_lc_addr", 64'(lc_log[n0].addr), 64'h00040);
    chk("t2_lc_data", lc_log[n0].data, 64'hAAAA);

    // Fill, single pop, ready returns one cycle after the pop.
    lc_force = 1'b0;
    n0 = lc_log.size();
    for (int i = 0; i < DEPTH; i++) l1_req(1'b1, AW'(32'h400 + i * 32'h40), 64'(i + 16));
    @(negedge clk_in);
    chk("t3_full_ready", 64'(l1_ready_out), 64'd0);
    lc_force = 1'b1;
    @(negedge clk_in);
    chk("t3_pop_cycle_ready", 64'(l1_ready_out), 64'd0);
    lc_force = 1'b0;
    @(negedge clk_in);
    chk("t3_after_pop_ready", 64'(l1_ready_out), 64'd1);
    chk("t3_one_pop", 64'(lc_log.size()), 64'(n0 + 1));
    chk("t3_pop_addr", 64'(lc_log[n0].addr), 64'h00400);
    lc_force = 1'b1;
    wait_empty("t3_drain");

    // A read miss overtakes a buffered writeback.
    lc_force = 1'b0;
    n0 = lc_log.size();
    l1_req(1'b1, 22'h00080, 64'h80);
    l1_req(1'b0, 22'h00100, 64'h0);
    lc_force = 1'b1;
    wait_empty("t4_drain");
    chk("t4_count", 64'(lc_log.size()), 64'(n0 + 2));
    chk("t4_first_we", 64'(lc_log[n0].we), 64'd0);
    chk("t4_first_addr", 64'(lc_log[n0].addr), 64'h00100);
    chk("t4_second_we", 64'(lc_log[n0 + 1].we), 64'd1);
    chk("t4_second_addr", 64'(lc_log[n0 + 1].addr), 64'h00080);

    // Same-address writes while the LC is stalled.
    lc_force = 1'b0;
    n0 = lc_log.size();
    l1_req(1'b1, 22'h000C0, 64'h1);
    l1_req(1'b1, 22'h000C0, 64'h2);
    l1_req(1'b0, 22'h000C0, 64'h0);
    @(negedge clk_in);
    chk("t5_resp_value", l1_resp_value_out, 64'h2);
    lc_force = 1'b1;
    wait_empty("t5_drain");
`ifdef WB_COALESCE_EN
    chk("t5_count", 64'(lc_log.size()), 64'(n0 + 1));
    chk("t5_data", lc_log[n0].data, 64'h2);
`else
    chk("t5_count", 64'(lc_log.size()), 64'(n0 + 2));
    chk("t5_first_data", lc_log[n0].data, 64'h1);
    chk("t5_second_data", lc_log[n0 + 1].data, 64'h2);
`endif

    // Asynchronous reset while a writeback is presented.
    lc_force = 1'b0;
    l1_req(1'b1, 22'h00140, 64'h66);
    n0 = 0;
    while (!lc_valid_out && n0 < 50) begin @(negedge clk_in); n0++; end
    chk("t6_presented", 64'(lc_valid_out), 64'd1);
    #2;
    mon_en   = 1'b0;
    rst_N_in = 1'b0;
    #1;
    chk("t6_lc_valid", 64'(lc_valid_out), 64'd0);
    chk("t6_lc_addr", 64'(lc_addr_out), 64'd0);
    chk("t6_empty", 64'(empty_out), 64'd1);
    chk("t6_ready", 64'(l1_ready_out), 64'd0);
    @(negedge clk_in);
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;
    mon_en = 1'b1;
    lc_force = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      chk("t6_stays_idle", 64'(lc_valid_out), 64'd0);
      chk("t6_stays_empty", 64'(empty_out), 64'd1);
    end
    @(posedge clk_in); #1;

    // Randomized traffic over a small address set to exercise hits and duplicates.
    rand_mode = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7)) << 6;
      l1_req($urandom_range(0, 1) == 1, a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_in);
        #1;
      end
    end
    rand_mode  = 1'b0;
    lc_force   = 1'b1;
    resp_force = 1'b1;
    wait_empty("rand_drain");
    @(negedge clk_in);
    chk("rand_model_drained", 64'(mq.size()), 64'd0);
    chk("rand_no_rd_left", 64'(exp_rd_pend), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l1d_writeback_buffer.md
Name: l1d_writeback_buffer

Overview:
Downstream neighbour of the L1 data cache, sitting between the L1D and the lower-level cache (LC). It holds dirty-line evictions (writebacks) in a small address-searchable FIFO and drains them to the LC. It also passes L1D read-miss requests through to the LC with priority. A read miss whose address matches a buffered writeback is answered directly from the buffer and never reaches the LC.

Parameters:
PADDR_BITS, 22, physical address width
DEPTH, 4, writeback entries (power of 2, >=2)
DATA_BITS, 64, data payload width

Ports:
clk_in  input  1  clock
rst_N_in  input  1  asynchronous active-low reset
l1_valid_in  input  1  L1D request valid
l1_ready_out  output  1  buffer can accept a request
l1_addr_in  input  PADDR_BITS  request physical address
l1_value_in  input  DATA_BITS  writeback data (ignored for reads)
l1_we_in  input  1  1 = writeback, 0 = read miss
l1_resp_valid_out  output  1  forwarded read response valid
l1_resp_ready_in  input  1  L1D accepts forwarded response
l1_resp_addr_out  output  PADDR_BITS  forwarded response address
l1_resp_value_out  output  DATA_BITS  forwarded response data
lc_valid_out  output  1  request to LC valid
lc_ready_in  input  1  LC accepts request
lc_addr_out  output  PADDR_BITS  LC request address
lc_value_out  output  DATA_BITS  LC writeback data
lc_we_out  output  1  LC request is a write
empty_out  output  1  no buffered writebacks and no pending read

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_N_in.
- During reset, all outputs are 0 except empty_out=1. Count is 0, rd/wr pointers are 0, the state is IDLE, and no read is pending. Reset mid-transfer drops all entries and any in-flight request; there is no partial drain.
- Accept rule: handshake on rising edge when l1_valid_in && l1_ready_out.
- l1_ready_out = !rd_pending && !resp_pending && (count < DEPTH). It is registered-state-derived and does not depend combinationally on l1_valid_in.
- Write accept: entry {addr, data} is pushed at the tail, or coalesced (see Optional Feature).
- Read accept: the address is compared against all valid entries in the same cycle.
  - Hit: the youngest matching entry's data is registered. l1_resp_valid_out=1 next cycle, with address and data. It is held stable until l1_resp_ready_in, then cleared.
  - Miss: the read is latched as rd_pending.
- LC drain FSM:
  - IDLE -> SEND_RD if rd_pending. Otherwise IDLE -> SEND_WB if count>0.
  - SEND_RD: lc_valid_out=1, lc_we_out=0, address = pending read. On lc_ready_in, clear rd_pending and go to IDLE.
  - SEND_WB: lc_valid_out=1, lc_we_out=1, address and data = head entry. On lc_ready_in, pop the head and go to IDLE.
  - The outputs of a request are stable from assertion until handshake. A read cannot preempt a WB already presented.
  - Throughput is one LC request per 2 cycles minimum (IDLE bubble).
- Simultaneous push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
- Full (count==DEPTH): l1_ready_out=0 until a pop. The pop cycle still deasserts ready; ready returns the following cycle.
- Forwarding respects pops: an entry popped in the same cycle as a read lookup still counts as a hit. The lookup uses pre-pop state.
- empty_out = (count==0) && !rd_pending && !resp_pending && (state==IDLE).

Optional Feature:
Macro WB_COALESCE_EN.
- Defined: a write whose address matches a valid entry overwrites that entry's data, and count is unchanged.
  - Exception: the head entry while state==SEND_WB is never coalesced; a new entry is allocated instead.
  - A coalescing write is accepted even when full. l1_ready_out then uses (count<DEPTH || a hit would occur) only if the implementation can compute it registered; otherwise full blocks.
- Undefined: every write allocates a new entry. Duplicates may coexist, and forwarding selects the youngest.

Test Plan:
1. Reset with l1_valid_in=1 -> all outputs 0, empty_out=1, l1_ready_out=0 during reset. ready=1 on the first cycle after release.
2. Write 0x00040/data 0xAAAA, then read 0x00040 -> l1_resp_valid_out next cycle with value 0xAAAA. No LC read is issued, and the LC later sees the WB 0x00040/0xAAAA.
3. Fill 4 writes with lc_ready_in=0 -> l1_ready_out=0 after the 4th. Raise lc_ready_in for 1 cycle -> one pop, then ready=1 the next cycle.
4. Buffer holds WB 0x00080 with state IDLE, and read 0x00100 arrives -> LC sees read 0x00100 (we=0) before WB 0x00080.
5. WB_COALESCE_EN: writes 0x000C0/0x1, then 0x000C0/0x2 while LC stalled -> count=1, and the LC receives a single WB with 0x2. Macro off -> count=2, two WBs in order 0x1, 0x2, and a read returns 0x2.
6. Assert rst_N_in low while lc_valid_out=1 in SEND_WB -> lc_valid_out drops immediately (async), count=0, empty_out=1.
